// File: rtl/reg_desp_param.sv
// Parametrised shift/rotate register with a per-cycle shift amount.
// A saturating moved-bit counter and DONE flag support serializer use.
module reg_desp_param #(
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(WIDTH),
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             ENB,
  input  logic             DIR,
  input  logic             S_IN,
  input  logic [1:0]       MODO,
  input  logic [AW-1:0]    AMT,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             S_OUT,
  output logic [CW-1:0]    CNT,
  output logic             DONE
);

  localparam int EW = CW + 1;
  localparam logic [EW-1:0] W_E   = EW'(WIDTH);
  localparam logic [EW-1:0] WM1_E = EW'(WIDTH - 1);
  localparam logic [1:0] M_SHIFT = 2'b00;
  localparam logic [1:0] M_ROT   = 2'b01;
  localparam logic [1:0] M_LOAD  = 2'b10;

  logic [WIDTH-1:0] q_q, q_d;
  logic             s_out_q, s_out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [EW-1:0]    amt_ext, k, rk, sum;
  logic [AW-1:0]    idx_l, idx_r;
  logic [WIDTH-1:0] ones_lo, ones_hi, shl, shr, rol, ror;
  logic             exit_bit;

  always_comb begin
    amt_ext = EW'(AMT);
    // Amounts past WIDTH-1 (non power-of-2 widths only) are clamped.
    k       = (amt_ext > WM1_E) ? WM1_E : amt_ext;
    rk      = W_E - k;
    ones_lo = ~({WIDTH{1'b1}} << k);
    ones_hi = ~({WIDTH{1'b1}} >> k);
    shl     = (q_q << k) | (S_IN ? ones_lo : '0);
    shr     = (q_q >> k) | (S_IN ? ones_hi : '0);
    rol     = (q_q << k) | (q_q >> rk);
    ror     = (q_q >> k) | (q_q << rk);
    // Last bit out: Q[WIDTH-k] going left, Q[k-1] going right.
    idx_l    = AW'(rk);
    idx_r    = AW'(k - EW'(1));
    exit_bit = DIR ? q_q[idx_l] : q_q[idx_r];
    sum      = EW'(cnt_q) + k;
  end

  always_comb begin
    q_d     = q_q;
    s_out_d = s_out_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    if (ENB) begin
      if (MODO == M_LOAD) begin
        q_d     = D;
        s_out_d = 1'b0;
        cnt_d   = '0;
        done_d  = 1'b0;
      end else if ((MODO == M_SHIFT || MODO == M_ROT) && k != '0) begin
        if (MODO == M_SHIFT) q_d = DIR ? shl : shr;
        else                 q_d = DIR ? rol : ror;
        s_out_d = exit_bit;
        cnt_d   = (sum >= W_E) ? CW'(WIDTH) : sum[CW-1:0];
        done_d  = (sum >= W_E);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      q_q     <= '0;
      s_out_q <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      s_out_q <= s_out_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign Q     = q_q;
  assign S_OUT = s_out_q;
  assign CNT   = cnt_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_reg_desp_param.sv
// Directed bench for reg_desp_param at WIDTH=8 with hand-computed expectations.
module tb_reg_desp_param;

  localparam int WIDTH = 8;
  localparam int AW    = 3;
  localparam int CW    = 4;

  logic             CLK = 1'b0;
  logic             RESET_L, ENB, DIR, S_IN;
  logic [1:0]       MODO;
  logic [AW-1:0]    AMT;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             S_OUT;
  logic [CW-1:0]    CNT;
  logic             DONE;

  int checks = 0;
  int errors = 0;

  reg_desp_param #(.WIDTH(WIDTH), .AW(AW), .CW(CW)) dut (
    .CLK(CLK), .RESET_L(RESET_L), .ENB(ENB), .DIR(DIR), .S_IN(S_IN),
    .MODO(MODO), .AMT(AMT), .D(D), .Q(Q), .S_OUT(S_OUT), .CNT(CNT), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    ENB = 1'b1; MODO = 2'b10; D = v;
    tick();
  endtask

  task automatic do_op(input logic [1:0] m, input logic dir, input logic [AW-1:0] amt, input logic sin);
    MODO = m; DIR = dir; AMT = amt; S_IN = sin;
    tick();
  endtask

  task automatic test_reset;
    RESET_L = 1'b0; ENB = 1'b1; DIR = 1'b0; S_IN = 1'b0; MODO = 2'b11; AMT = '0; D = '0;
    #1;
    checks++;
    if ({Q, S_OUT, CNT, DONE} !== {8'h00, 1'b0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_initial: Q=%h S_OUT=%b CNT=%0d DONE=%b, expected 00 0 0 0", Q, S_OUT, CNT, DONE);
    end
    tick();
    RESET_L = 1'b1;
    do_load(8'hA5);
    checks++;
    if (Q !== 8'hA5) begin
      errors++;
      $display("FAIL reset_preload: Q=%h expected a5", Q);
    end
    #2 RESET_L = 1'b0;
    #1;
    checks++;
    if ({Q, S_OUT, CNT, DONE} !== {8'h00, 1'b0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_async: Q=%h S_OUT=%b CNT=%0d DONE=%b, expected 00 0 0 0", Q, S_OUT, CNT, DONE);
    end
    tick(); tick();
    checks++;
    if ({Q, S_OUT, CNT, DONE} !== {8'h00, 1'b0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_held: Q=%h S_OUT=%b CNT=%0d DONE=%b, expected 00 0 0 0", Q, S_OUT, CNT, DONE);
    end
    RESET_L = 1'b1;
    do_op(2'b00, 1'b1, 3'd1, 1'b1);
    checks++;
    if ({Q, S_OUT, CNT, DONE} !== {8'h01, 1'b0, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL reset_release_shift: Q=%h S_OUT=%b CNT=%0d DONE=%b, expected 01 0 1 0", Q, S_OUT, CNT, DONE);
    end
  endtask

  task automatic test_load_shift;
    do_load(8'hB4);
    checks++;
    if ({Q, S_OUT, CNT, DONE} !== {8'hB4, 1'b0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL load: Q=%h S_OUT=%b CNT=%0d DONE=%b, expected b4 0 0 0", Q, S_OUT, CNT, DONE);
    end
    do_op(2'b00, 1'b1, 3'd1, 1'b1);
    checks++;
    if ({Q, S_OUT, CNT, DONE} !== {8'h69, 1'b1, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL shl1_a: Q=%h S_OUT=%b CNT=%0d DONE=%b, expected 69 1 1 0", Q, S_OUT, CNT, DONE);
    end
    tick();
    checks++;
    if ({Q, S_OUT, CNT, DONE} !== {8'hD3, 1'b0, 4'd2, 1'b0}) begin
      errors++;
      $display("FAIL shl1_b: Q=%h S_OUT=%b CNT=%0d DONE=%b, expected d3 0 2 0", Q, S_OUT, CNT, DONE);
    end
  endtask

  task automatic test_multi_shift;
    do_load(8'hF0);
    do_op(2'b00, 1'b0, 3'd3, 1'b0);
    checks++;
    if ({Q, S_OUT, CNT, DONE} !== {8'h1E, 1'b0, 4'd3, 1'b0}) begin
      errors++;
      $display("FAIL shr3: Q=%h S_OUT=%b CNT=%0d DONE=%b, expected 1e 0 3 0", Q, S_OUT, CNT, DONE);
    end
    do_load(8'h00);
    do_op(2'b00, 1'b0, 3'd2, 1'b1);
    checks++;
    if ({Q, S_OUT, CNT, DONE} !== {8'hC0, 1'b0, 4'd2, 1'b0}) begin
      errors++;
      $display("FAIL shr2_fill: Q=%h S_OUT=%b CNT=%0d DONE=%b, expected c0 0 2 0", Q, S_OUT, CNT, DONE);
    end
  endtask

  task automatic test_rotate;
    do_load(8'h81);
    do_op(2'b01, 1'b1, 3'd2, 1'b1);
    checks++;
    if ({Q, S_OUT, CNT, DONE} !== {8'h06, 1'b0, 4'd2, 1'b0}) begin
      errors++;
      $display("FAIL rol2: Q=%h S_OUT=%b CNT=%0d DONE=%b, expected 06 0 2 0", Q, S_OUT, CNT, DONE);
    end
    do_op(2'b01, 1'b0, 3'd1, 1'b1);
    checks++;
    if ({Q, S_OUT, CNT, DONE} !== {8'h03, 1'b0, 4'd3, 1'b0}) begin
      errors++;
      $display("FAIL ror1: Q=%h S_OUT=%b CNT=%0d DONE=%b, expected 03 0 3 0", Q, S_OUT, CNT, DONE);
    end
    do_load(8'h85);
    do_op(2'b01, 1'b0, 3'd3, 1'b0);
    checks++;
    if ({Q, S_OUT, CNT, DONE} !== {8'hB0, 1'b1, 4'd3, 1'b0}) begin
      errors++;
      $display("FAIL ror3: Q=%h S_OUT=%b CNT=%0d DONE=%b, expected b0 1 3 0", Q, S_OUT, CNT, DONE);
    end
  endtask

  task automatic test_done;
    logic [WIDTH-1:0] exp_q [4];
    logic [CW-1:0]    exp_c [4];
    logic             exp_d [4];
    exp_q = '{8'h18, 8'h03, 8'h00, 8'h00};
    exp_c = '{4'd3, 4'd6, 4'd8, 4'd8};
    exp_d = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_load(8'hC3);
    for (int i = 0; i < 4; i++) begin
      do_op(2'b00, 1'b0, 3'd3, 1'b0);
      checks++;
      if ({Q, S_OUT, CNT, DONE} !== {exp_q[i], 1'b0, exp_c[i], exp_d[i]}) begin
        errors++;
        $display("FAIL serial_step%0d: Q=%h S_OUT=%b CNT=%0d DONE=%b, expected %h 0 %0d %b",
                 i, Q, S_OUT, CNT, DONE, exp_q[i], exp_c[i], exp_d[i]);
      end
    end
    do_load(8'h3C);
    checks++;
    if ({Q, S_OUT, CNT, DONE} !== {8'h3C, 1'b0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL serial_reload: Q=%h S_OUT=%b CNT=%0d DONE=%b, expected 3c 0 0 0", Q, S_OUT, CNT, DONE);
    end
  endtask

  task automatic test_hold;
    do_load(8'hA5);
    do_op(2'b00, 1'b1, 3'd1, 1'b0);
    checks++;
    if ({Q, S_OUT, CNT, DONE} !== {8'h4A, 1'b1, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL hold_setup: Q=%h S_OUT=%b CNT=%0d DONE=%b, expected 4a 1 1 0", Q, S_OUT, CNT, DONE);
    end
    ENB = 1'b0;
    do_op(2'b00, 1'b1, 3'd2, 1'b1);
    checks++;
    if ({Q, S_OUT, CNT, DONE} !== {8'h4A, 1'b1, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL enb_off_shift: Q=%h S_OUT=%b CNT=%0d DONE=%b, expected 4a 1 1 0", Q, S_OUT, CNT, DONE);
    end
    D = 8'hFF;
    do_op(2'b10, 1'b0, 3'd0, 1'b0);
    checks++;
    if ({Q, S_OUT, CNT, DONE} !== {8'h4A, 1'b1, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL enb_off_load: Q=%h S_OUT=%b CNT=%0d DONE=%b, expected 4a 1 1 0", Q, S_OUT, CNT, DONE);
    end
    ENB = 1'b1;
    do_op(2'b11, 1'b1, 3'd3, 1'b1);
    checks++;
    if ({Q, S_OUT, CNT, DONE} !== {8'h4A, 1'b1, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL modo_hold: Q=%h S_OUT=%b CNT=%0d DONE=%b, expected 4a 1 1 0", Q, S_OUT, CNT, DONE);
    end
    do_op(2'b00, 1'b0, 3'd0, 1'b1);
    checks++;
    if ({Q, S_OUT, CNT, DONE} !== {8'h4A, 1'b1, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL amt_zero_shift: Q=%h S_OUT=%b CNT=%0d DONE=%b, expected 4a 1 1 0", Q, S_OUT, CNT, DONE);
    end
    do_op(2'b01, 1'b1, 3'd0, 1'b0);
    checks++;
    if ({Q, S_OUT, CNT, DONE} !== {8'h4A, 1'b1, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL amt_zero_rot: Q=%h S_OUT=%b CNT=%0d DONE=%b, expected 4a 1 1 0", Q, S_OUT, CNT, DONE);
    end
  endtask

  initial begin
    test_reset();
    test_load_shift();
    test_multi_shift();
    test_rotate();
    test_done();
    test_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_desp_param.md
Name: reg_desp_param

Overview:
- Parametrised successor to the 32-bit shift register; same four-mode MODO control and serial/parallel interface.
- Width is generalised and a multi-bit shift/rotate amount per cycle is added.
- A shifted-bit counter with a DONE flag supports serializer use: load a word, shift until all WIDTH bits have left the register.
- Sits between the probador and the serial link in the Tarea benches; checked against a conductual model by a verificador.

Parameters:
- WIDTH, 32: register width in bits; legal range 4 to 64.
- AW, $clog2(WIDTH): width of the AMT input.
- CW, $clog2(WIDTH)+1: width of the bit counter CNT.

Ports:
- CLK  input  1  single clock, rising-edge.
- RESET_L  input  1  asynchronous active-low reset.
- ENB  input  1  global enable; 0 freezes all state.
- DIR  input  1  1 = toward MSB (left), 0 = toward LSB (right).
- S_IN  input  1  serial fill bit for MODO=00.
- MODO  input  2  00 shift, 01 rotate, 10 parallel load, 11 hold.
- AMT  input  AW  positions moved per cycle in modes 00/01.
- D  input  WIDTH  parallel load data.
- Q  output  WIDTH  register contents (registered).
- S_OUT  output  1  last bit to leave the exit end (registered).
- CNT  output  CW  bits moved since last load; saturates at WIDTH.
- DONE  output  1  high while CNT == WIDTH.

Behaviour:
- Reset: RESET_L=0 immediately forces Q=0, S_OUT=0, CNT=0, DONE=0, independent of CLK. Release is sampled at the next rising edge.
- All updates happen on the rising CLK edge with one-cycle latency. ENB=0 holds Q, S_OUT, CNT and DONE regardless of MODO.
- MODO=10 (load): Q<=D, S_OUT<=0, CNT<=0, DONE<=0. AMT and DIR are ignored.
- MODO=00 (shift), AMT=k, 1<=k<=WIDTH-1:
  - DIR=1: Q<={Q[WIDTH-1-k:0], k copies of S_IN}; S_OUT<=Q[WIDTH-k].
  - DIR=0: Q<={k copies of S_IN, Q[WIDTH-1:k]}; S_OUT<=Q[k-1].
  - S_OUT is the bit nearest the exit end's interior among the bits that left, i.e. the last one out.
- MODO=01 (rotate): Q rotates by k in direction DIR, with no S_IN use. S_OUT takes the same bit index as in shift mode (the bit that wrapped last).
- AMT=0 in modes 00/01: Q, S_OUT and CNT hold (no movement).
- CNT, modes 00/01 only: CNT<=min(CNT+k, WIDTH), so it saturates with no wrap. DONE<=(CNT+k >= WIDTH). Once DONE=1, further shifts keep CNT=WIDTH and DONE=1 until a load or reset.
- MODO=11 (hold): everything holds.
- Simultaneous events: load has priority by encoding. A DIR or AMT change takes effect on the same edge it is sampled. S_IN is sampled once per edge and replicated k times.
- AMT values >= WIDTH, only reachable when WIDTH is not a power of 2: treated as WIDTH-1 (clamped).
- Reset asserted mid-shift: the state clears asynchronously, and the next operation after release starts from Q=0, CNT=0.
- No latches. Q, S_OUT, CNT and DONE are the only state.

Test Plan (bench instantiates WIDTH=8; reg_conductual-style reference model plus verificador_r compare Q each cycle, ALERTA must stay 0):
- Reset: RESET_L=0 mid-cycle with Q=8'hA5 -> Q=0, S_OUT=0, CNT=0, DONE=0 before the next edge; hold RESET_L=0 two edges -> still 0.
- Load then shift-left-1: D=8'hB4, MODO=10, then MODO=00, DIR=1, AMT=1, S_IN=1 -> Q=8'h69, S_OUT=1, CNT=1; the next edge gives Q=8'hD3, S_OUT=0, CNT=2.
- Multi-bit right shift: load 8'hF0; MODO=00, DIR=0, AMT=3, S_IN=0 -> Q=8'h1E, S_OUT=0 (old Q[2]), CNT=3.
- Rotate: load 8'h81; MODO=01, DIR=1, AMT=2 -> Q=8'h06, S_OUT=0 (old Q[6]); then DIR=0, AMT=1 -> Q=8'h03, S_OUT=0.
- Serializer/DONE: load 8'hC3; MODO=00, DIR=0, AMT=3 for 3 edges -> CNT 3, 6, 8 (saturated), DONE rises on the third edge. A 4th shift keeps CNT=8, DONE=1. A subsequent load clears both.
- Enable/hold/AMT=0: ENB=0 with MODO=00 -> no change. MODO=11 -> no change. MODO=00 with AMT=0 -> Q, S_OUT, CNT unchanged.
